hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter REG_W, default 3, meaning register-specifier width (8 architectural registers).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning in-flight stages tracked after decode (EX..WB-1), range 1..8.
REQ-003 The module SHALL have parameter FWD_MODE, default 0: 0 = no forwarding, 1 = full forwarding except load-use.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 The ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  decode stage holds a real instruction.
REQ-008 id_rs, id_rt  in  REG_W each  source specifiers.
REQ-009 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-010 id_rd  in  REG_W  destination specifier.
REQ-011 id_rd_wr  in  1  instruction writes id_rd.
REQ-012 id_is_load  in  1  instruction is a memory load.
REQ-013 flush  in  1  squash all tracked in-flight instructions (branch/jump redirect).
REQ-014 clr_cnt  in  1  synchronous clear of stall_cnt.
REQ-015 stall  out  1  hold PC/IF/ID and inject a bubble into EX.
REQ-016 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 The block SHALL keep a DEPTH-entry history shift register; entry k (1 = EX) holds {valid, wr, rd, is_load}.
REQ-018 Each rising edge, entry k SHALL move to k+1, and entry DEPTH SHALL be discarded.
REQ-019 Entry 1 SHALL load {id_valid & ~stall, id_rd_wr, id_rd, id_is_load}, so a stall inserts a bubble.
REQ-020 A source SHALL match entry k when used & entry.valid & entry.wr & (entry.rd == source).
REQ-021 With FWD_MODE=0, stall SHALL be high when id_valid and either source matches any entry 1..DEPTH.
REQ-022 With FWD_MODE=1, stall SHALL be high only when id_valid and a source matches entry 1 with is_load=1.
REQ-023 stall SHALL be combinational from the current ID inputs and history, with zero-cycle latency.
REQ-024 On flush, stall SHALL be 0 that cycle, and at the edge all entries SHALL become invalid, including the incoming ID instruction (flush wins over stall).
REQ-025 Register 0 SHALL be treated as an ordinary register; no specifier is exempt.
REQ-026 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL saturate at all ones.
REQ-027 When clr_cnt and stall coincide, stall_cnt SHALL become 0 (clear wins).
REQ-028 A dependency on a writer in entry DEPTH SHALL still stall, because the register file bypasses the WB write.
REQ-029 Stall SHALL therefore release the cycle after the writer leaves entry DEPTH.

Reset
REQ-030 While rst=1, asynchronously: all history entries SHALL be invalid (all fields 0), stall_cnt = 0, and stall = 0.
REQ-031 Reset asserted mid-stall SHALL drop stall immediately.
REQ-032 After release, tracking SHALL start from an empty history on the first edge.

Structure
REQ-033 The default REG_W, DEPTH and CNT_W values and the history-entry field widths SHALL live in the shared project defines/package file.
REQ-034 One sub-module, hazard_hist_stage, SHALL implement a single history entry (async-reset flop set with flush clear) and SHALL be instantiated DEPTH times.
REQ-035 Comparators and the stall OR-tree SHALL be in the top level.

Verification
REQ-036 FWD_MODE=0, DEPTH=4: ADD writes r3, next cycle an instruction reads r3 -> stall=1 for exactly 4 cycles, 4 bubbles in history, stall_cnt=4.
REQ-037 FWD_MODE=1: a load to r5 followed by a read of r5 -> stall=1 for exactly 1 cycle; a non-load writer of r5 followed by a read of r5 -> stall=0.
REQ-038 Stall in progress (r2 dependency) plus flush asserted -> stall=0 same cycle; a following read of r2 -> stall=0.
REQ-039 CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15; clr_cnt together with stall -> stall_cnt=0.
REQ-040 rst asserted mid-stall, asynchronously between edges -> stall=0 and stall_cnt=0 immediately; a dependent read after release -> stall=0.
REQ-041 id_rt_used=0 with id_rt matching an in-flight rd, or id_valid=0 -> stall=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared defaults and history-entry layout for the pipeline hazard unit.
// An entry is packed as {valid, wr, is_load, rd} with rd in the low bits.
package hazard_unit_pkg;

  localparam int REG_W_DEF = 3;
  localparam int DEPTH_DEF = 4;
  localparam int DEPTH_MAX = 8;
  localparam int CNT_W_DEF = 16;

  localparam int FWD_NONE = 0;
  localparam int FWD_FULL = 1;

  // Control bits sit above the rd field; offsets are relative to REG_W.
  localparam int HIST_CTRL_W  = 3;
  localparam int HIST_VLD_OFS = 2;
  localparam int HIST_WR_OFS  = 1;
  localparam int HIST_LD_OFS  = 0;

  function automatic int hist_w(input int reg_w);
    return reg_w + HIST_CTRL_W;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage view handed to the hazard unit, plus its stall response.
interface hazard_unit_if
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic             id_rs_used;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_wr;
  logic             id_is_load;
  logic             flush;
  logic             clr_cnt;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
    output id_rd, id_rd_wr, id_is_load, flush, clr_cnt,
    input  stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
    input  id_rd, id_rd_wr, id_is_load, flush, clr_cnt,
    output stall, stall_cnt
  );

endinterface

// File: rtl/hazard_unit_hist_stage.sv
// One in-flight history entry: async-reset register that a flush clears.
module hazard_hist_stage #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Interlock for an in-order pipeline: stalls decode while a source depends on
// an in-flight writer, and counts stall cycles in a saturating counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int FWD_MODE = FWD_NONE,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic           clk,
  input logic           rst,
  hazard_unit_if.slave  hz
);

  localparam int HW     = hist_w(REG_W);
  localparam int VLD_B  = REG_W + HIST_VLD_OFS;
  localparam int WR_B   = REG_W + HIST_WR_OFS;
  localparam int LD_B   = REG_W + HIST_LD_OFS;

  logic [HW-1:0]    hist_d [1:DEPTH];
  logic [HW-1:0]    hist_q [1:DEPTH];
  logic [DEPTH:1]   rs_hit;
  logic [DEPTH:1]   rt_hit;
  logic             dep_any;
  logic             dep_load;
  logic             dep;
  logic             stall;
  logic [CNT_W-1:0] cnt_q;

  // A stalled decode slot enters EX as a bubble.
  assign hist_d[1] = {hz.id_valid & ~stall, hz.id_rd_wr, hz.id_is_load, hz.id_rd};

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    if (k > 1) begin : g_chain
      assign hist_d[k] = hist_q[k-1];
    end
    hazard_hist_stage #(.W(HW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (hz.flush),
      .d     (hist_d[k]),
      .q     (hist_q[k])
    );
  end

  always_comb begin
    rs_hit = '0;
    rt_hit = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      rs_hit[k] = hz.id_rs_used & hist_q[k][VLD_B] & hist_q[k][WR_B] &
                  (hist_q[k][REG_W-1:0] == hz.id_rs);
      rt_hit[k] = hz.id_rt_used & hist_q[k][VLD_B] & hist_q[k][WR_B] &
                  (hist_q[k][REG_W-1:0] == hz.id_rt);
    end
  end

  // The last entry still counts: its WB write reaches ID via the regfile bypass
  // only in the same cycle, so the reader must wait until it has left.
  assign dep_any  = |(rs_hit | rt_hit);
  assign dep_load = (rs_hit[1] | rt_hit[1]) & hist_q[1][LD_B];
  assign dep      = (FWD_MODE == FWD_NONE) ? dep_any : dep_load;
  assign stall    = hz.id_valid & dep & ~hz.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hz.clr_cnt) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hz.stall     = stall;
  assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench: three hazard units (no forwarding, forwarding, 4-bit counter).
module tb_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic       rs_used;
    logic [2:0] rt;
    logic       rt_used;
    logic [2:0] rd;
    logic       rd_wr;
    logic       is_load;
    logic       flush;
    logic       clr_cnt;
  } drv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  drv_t drv = '0;

  int    n_run  = 0;
  int    n_fail = 0;
  int    exp_q[$];
  string tag_q[$];

  hazard_unit_if #(.REG_W(3), .CNT_W(16)) hz0 ();
  hazard_unit_if #(.REG_W(3), .CNT_W(16)) hz1 ();
  hazard_unit_if #(.REG_W(3), .CNT_W(4))  hz2 ();

  assign {hz0.id_valid, hz0.id_rs, hz0.id_rs_used, hz0.id_rt, hz0.id_rt_used,
          hz0.id_rd, hz0.id_rd_wr, hz0.id_is_load, hz0.flush, hz0.clr_cnt} = drv;
  assign {hz1.id_valid, hz1.id_rs, hz1.id_rs_used, hz1.id_rt, hz1.id_rt_used,
          hz1.id_rd, hz1.id_rd_wr, hz1.id_is_load, hz1.flush, hz1.clr_cnt} = drv;
  assign {hz2.id_valid, hz2.id_rs, hz2.id_rs_used, hz2.id_rt, hz2.id_rt_used,
          hz2.id_rd, hz2.id_rd_wr, hz2.id_is_load, hz2.flush, hz2.clr_cnt} = drv;

  hazard_unit #(.REG_W(3), .DEPTH(4), .FWD_MODE(0), .CNT_W(16)) u_fwd0 (.clk(clk), .rst(rst), .hz(hz0));
  hazard_unit #(.REG_W(3), .DEPTH(4), .FWD_MODE(1), .CNT_W(16)) u_fwd1 (.clk(clk), .rst(rst), .hz(hz1));
  hazard_unit #(.REG_W(3), .DEPTH(4), .FWD_MODE(0), .CNT_W(4))  u_cnt4 (.clk(clk), .rst(rst), .hz(hz2));

  logic [2:0] st;
  assign st = {hz2.stall, hz1.stall, hz0.stall};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_stall(input string tag, input int e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input int sel);
    int    e;
    string t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, int'(st[sel]), e);
    end
  endtask

  function automatic drv_t op(input logic v, input logic [2:0] rs, input logic rsu,
                              input logic [2:0] rt, input logic rtu,
                              input logic [2:0] rd, input logic wr, input logic ld);
    drv_t d;
    d = '0;
    d.valid = v;  d.rs = rs;  d.rs_used = rsu;  d.rt = rt;  d.rt_used = rtu;
    d.rd = rd;    d.rd_wr = wr;  d.is_load = ld;
    return d;
  endfunction

  // Called at posedge+1; drives, samples stall mid-cycle, returns at next posedge+1.
  task automatic step(input int sel, input drv_t d, input int e, input string tag);
    drv = d;
    expect_stall(tag, e);
    #2;
    observe(sel);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_t w, r, d;

    #1;
    chk("rst_stall0", int'(hz0.stall), 0);
    chk("rst_stall1", int'(hz1.stall), 0);
    chk("rst_cnt0", int'(hz0.stall_cnt), 0);
    chk("rst_cnt2", int'(hz2.stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No forwarding: writer of r3, then reader of r3 waits the full depth.
    w = op(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0);
    r = op(1, 3'd3, 1, 3'd0, 1, 3'd4, 1, 0);
    step(0, w, 0, "raw_writer");
    for (int i = 1; i <= 4; i++) begin
      step(0, r, 1, "raw_stall");
      chk("raw_cnt", int'(hz0.stall_cnt), i);
    end
    step(0, r, 0, "raw_release");
    chk("raw_cnt_final", int'(hz0.stall_cnt), 4);
    step(0, '0, 0, "raw_nop");

    // Unused rt and invalid decode never stall; a real reader does.
    do_reset();
    step(0, op(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0), 0, "w6");
    step(0, op(1, 3'd1, 1, 3'd6, 0, 3'd0, 0, 0), 0, "rt_unused");
    step(0, op(0, 3'd6, 1, 3'd6, 1, 3'd0, 0, 0), 0, "id_invalid");
    step(0, op(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0), 1, "rs6_entry3");

    // r0 is an ordinary register.
    do_reset();
    step(0, op(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0), 0, "w0");
    step(0, op(1, 3'd0, 0, 3'd0, 1, 3'd1, 0, 0), 1, "r0_dep");

    // Forwarding: only load-use in EX stalls, for one cycle.
    do_reset();
    step(1, op(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1), 0, "ld_r5");
    step(1, op(1, 3'd5, 1, 3'd0, 0, 3'd2, 1, 0), 1, "load_use");
    step(1, op(1, 3'd5, 1, 3'd0, 0, 3'd2, 1, 0), 0, "load_use_release");
    chk("fwd_cnt", int'(hz1.stall_cnt), 1);
    step(1, op(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0), 0, "alu_r5");
    step(1, op(1, 3'd0, 0, 3'd5, 1, 3'd2, 1, 0), 0, "alu_use");

    // Flush kills the stall the same cycle and empties history.
    do_reset();
    r = op(1, 3'd2, 1, 3'd0, 0, 3'd7, 1, 0);
    step(0, op(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0), 0, "w2");
    drv = r;
    expect_stall("pre_flush", 1);
    #2;
    observe(0);
    drv.flush = 1'b1;
    expect_stall("flush_same_cycle", 0);
    #1;
    observe(0);
    @(posedge clk);
    #1;
    step(0, r, 0, "after_flush");
    chk("flush_cnt", int'(hz0.stall_cnt), 0);

    // 4-bit counter saturation, then clear winning over stall.
    do_reset();
    w = op(1, 3'd1, 1, 3'd0, 0, 3'd1, 1, 0);
    step(2, op(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0), 0, "w1");
    for (int rnd = 0; rnd < 5; rnd++) begin
      for (int i = 0; i < 4; i++) step(2, w, 1, "sat_stall");
      step(2, w, 0, "sat_release");
      chk("sat_cnt", int'(hz2.stall_cnt), (4 * (rnd + 1) > 15) ? 15 : 4 * (rnd + 1));
    end
    d = w;
    d.clr_cnt = 1'b1;
    step(2, d, 1, "clr_with_stall");
    chk("clr_cnt", int'(hz2.stall_cnt), 0);
    step(2, w, 1, "post_clr_stall");
    chk("post_clr_cnt", int'(hz2.stall_cnt), 1);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    r = op(1, 3'd4, 1, 3'd0, 0, 3'd3, 1, 0);
    step(0, op(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0), 0, "w4");
    step(0, r, 1, "r4_stall_a");
    step(0, r, 1, "r4_stall_b");
    chk("pre_rst_cnt", int'(hz0.stall_cnt), 2);
    drv = r;
    expect_stall("r4_stall_c", 1);
    #2;
    observe(0);
    rst = 1'b1;
    expect_stall("async_rst_stall", 0);
    #1;
    observe(0);
    chk("async_rst_cnt", int'(hz0.stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, r, 0, "after_rst_read");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
